// File: rtl/ofmap_packer.sv
// Regroups POY result beats of POX lanes into one tile word, queues tiles in a
// small FIFO and hands them to the output writer with per-layer count/last/done.
module ofmap_packer #(
    parameter int POX        = 3,
    parameter int POY        = 3,
    parameter int DEPTH      = 4,
    parameter int TILE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [TILE_CNT_W-1:0]   num_tiles,
    input  logic [POX*16-1:0]       post_out,
    input  logic                    post_out_valid,
    output logic [POY*POX*16-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    localparam int LW    = POX * 16;
    localparam int TW    = POY * LW;
    localparam int ROW_W = (POY > 1) ? $clog2(POY) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(POY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [TILE_CNT_W-1:0]  tiles_q;
    logic [TILE_CNT_W-1:0]  tile_cnt;
    logic [ROW_W-1:0]       row_cnt;
    logic [LW-1:0]          stage [POY-1];
    logic [TW-1:0]          mem [DEPTH];
    logic [DEPTH-1:0]       last_mem;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   done_q;
    logic                   ovf_q;

    logic [TW-1:0]          tile;
    logic                   beat_go;
    logic                   tile_done;
    logic                   full;
    logic                   is_last_tile;
    logic                   push;
    logic                   pop;

    // The completing beat goes straight into the tile; it is never staged.
    always_comb begin
        tile = '0;
        for (int r = 0; r < POY - 1; r++)
            tile[r*LW +: LW] = stage[r];
        tile[(POY-1)*LW +: LW] = post_out;
    end

    assign beat_go      = (state == RUN) && post_out_valid && !start;
    assign tile_done    = beat_go && (row_cnt == ROW_LAST);
    // Full check uses the registered count only: a same-cycle pop does not rescue the tile.
    assign full         = (count == CNT_W'(DEPTH));
    assign is_last_tile = (tile_cnt == tiles_q - 1'b1);
    assign push         = tile_done && !full;
    assign pop          = out_valid && out_ready && !start;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign out_last  = last_mem[rd_ptr];
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tiles_q  <= '0;
            tile_cnt <= '0;
            row_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            last_mem <= '0;
            for (int r = 0; r < POY - 1; r++) stage[r] <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // Also the abort path: no done for a layer cut short.
                tiles_q  <= num_tiles;
                tile_cnt <= '0;
                row_cnt  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                ovf_q    <= 1'b0;
                if (num_tiles == '0) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end else begin
                    state  <= RUN;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr]      <= tile;
                    last_mem[wr_ptr] <= is_last_tile;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;

                unique case (state)
                    RUN: begin
                        if (tile_done) begin
                            row_cnt  <= '0;
                            tile_cnt <= tile_cnt + 1'b1;
                            if (full) ovf_q <= 1'b1;
                            if (is_last_tile) state <= DRAIN;
                        end else if (beat_go) begin
                            for (int r = 0; r < POY - 1; r++)
                                if (row_cnt == ROW_W'(r)) stage[r] <= post_out;
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (count == '0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ofmap_packer.sv
// Directed bench for ofmap_packer: expected tiles queued as beats are driven,
// checked as the writer side pops them.
module tb_ofmap_packer;
    localparam int POX = 3, POY = 3, DEPTH = 4, TCW = 16;
    localparam int TW = POY * POX * 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [TCW-1:0]    num_tiles = '0;
    logic [POX*16-1:0] post_out = '0;
    logic              post_out_valid = 1'b0;
    logic [TW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              overflow;

    typedef struct { logic [TW-1:0] d; logic l; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0, n_pop = 0;

    ofmap_packer #(.POX(POX), .POY(POY), .DEPTH(DEPTH), .TILE_CNT_W(TCW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .post_out(post_out), .post_out_valid(post_out_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk_tile(input logic [15:0] v0);
        logic [TW-1:0] t;
        logic [15:0] v;
        t = '0;
        for (int r = 0; r < POY; r++) begin
            v = v0 + 16'(r);
            t[r*48 +: 48] = {v, v, v};
        end
        return t;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input logic [15:0] v, input int gap);
        post_out = {v, v, v};
        post_out_valid = 1'b1;
        cyc(1);
        post_out_valid = 1'b0;
        cyc(gap);
    endtask

    task automatic send_tile(input logic [15:0] v0, input int idx, input int n,
                             input bit store, input int gap);
        exp_t e;
        for (int r = 0; r < POY; r++) begin
            if (r == POY - 1 && store) begin
                e.d = mk_tile(v0);
                e.l = (idx == n - 1);
                sb.push_back(e);
            end
            beat(v0 + 16'(r), gap);
        end
    endtask

    task automatic do_start(input int n);
        num_tiles = TCW'(n);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        chk(tag, TW'(got), TW'(1));
        if (got) chk({tag, "_busy_low"}, TW'(busy), TW'(0));
        @(posedge clk); #1;
    endtask

    // Writer side: every accepted tile must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_pop++;
            chk("pop_expected", TW'(sb.size() != 0), TW'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_data", out_data, e.d);
                chk("pop_last", TW'(out_last), TW'(e.l));
            end
        end
    end

    initial begin
        // Reset state
        cyc(2);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_valid", TW'(out_valid), TW'(0));
        chk("rst_busy", TW'(busy), TW'(0));
        chk("rst_done", TW'(done), TW'(0));
        chk("rst_overflow", TW'(overflow), TW'(0));
        rst = 1'b0;
        cyc(1);

        // Two tiles back-to-back, ready held high
        out_ready = 1'b1;
        n_pop = 0;
        do_start(2);
        chk("t1_busy_after_start", TW'(busy), TW'(1));
        send_tile(16'h0001, 0, 2, 1'b1, 0);
        send_tile(16'h0004, 1, 2, 1'b1, 0);
        wait_done("t1_done", 10);
        chk("t1_pops", TW'(n_pop), TW'(2));
        chk("t1_overflow", TW'(overflow), TW'(0));

        // Output held under back-pressure, then drained
        out_ready = 1'b0;
        n_pop = 0;
        do_start(2);
        send_tile(16'h0011, 0, 2, 1'b1, 0);
        send_tile(16'h0021, 1, 2, 1'b1, 0);
        chk("t2_head_early", out_data, sb[0].d);
        cyc(20);
        chk("t2_valid_held", TW'(out_valid), TW'(1));
        chk("t2_head_stable", out_data, sb[0].d);
        chk("t2_head_last", TW'(out_last), TW'(0));
        chk("t2_busy_drain", TW'(busy), TW'(1));
        out_ready = 1'b1;
        wait_done("t2_done", 10);
        chk("t2_pops", TW'(n_pop), TW'(2));

        // Overflow: six tiles into a four-deep FIFO with no readers
        out_ready = 1'b0;
        n_pop = 0;
        do_start(6);
        for (int i = 0; i < 4; i++)
            send_tile(16'h0100 + 16'(i * 16), i, 6, 1'b1, 0);
        chk("t3_no_ovf_yet", TW'(overflow), TW'(0));
        send_tile(16'h0140, 4, 6, 1'b0, 0);
        chk("t3_ovf_after_tile4", TW'(overflow), TW'(1));
        send_tile(16'h0150, 5, 6, 1'b0, 0);
        cyc(1);
        chk("t3_busy_drain", TW'(busy), TW'(1));
        out_ready = 1'b1;
        wait_done("t3_done", 20);
        chk("t3_pops", TW'(n_pop), TW'(4));
        chk("t3_ovf_sticky", TW'(overflow), TW'(1));

        // Gapped input, pop coincides with push at count 3
        out_ready = 1'b0;
        n_pop = 0;
        do_start(4);
        chk("t4_ovf_cleared", TW'(overflow), TW'(0));
        for (int i = 0; i < 3; i++)
            send_tile(16'h0300 + 16'(i * 16), i, 4, 1'b1, 2);
        chk("t4_valid", TW'(out_valid), TW'(1));
        beat(16'h0330, 2);
        beat(16'h0331, 2);
        sb.push_back('{d: mk_tile(16'h0330), l: 1'b1});
        out_ready = 1'b1;
        beat(16'h0332, 2);
        wait_done("t4_done", 40);
        chk("t4_pops", TW'(n_pop), TW'(4));
        chk("t4_no_ovf", TW'(overflow), TW'(0));
        chk("t4_sb_empty", TW'(sb.size()), TW'(0));

        // Empty layer and beats while idle
        do_start(0);
        chk("t5_done", TW'(done), TW'(1));
        chk("t5_busy", TW'(busy), TW'(0));
        cyc(1);
        chk("t5_done_pulse", TW'(done), TW'(0));
        chk("t5_busy_still", TW'(busy), TW'(0));
        beat(16'h0055, 0);
        beat(16'h0056, 0);
        beat(16'h0057, 0);
        cyc(2);
        chk("t5_idle_no_valid", TW'(out_valid), TW'(0));
        chk("t5_idle_no_ovf", TW'(overflow), TW'(0));

        // Abort mid-layer, with a beat coincident with start
        out_ready = 1'b0;
        do_start(3);
        send_tile(16'h0200, 0, 3, 1'b0, 0);
        beat(16'h0300, 0);
        chk("t6_valid_pre_abort", TW'(out_valid), TW'(1));
        post_out = {16'h0099, 16'h0099, 16'h0099};
        post_out_valid = 1'b1;
        num_tiles = TCW'(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        post_out_valid = 1'b0;
        chk("t6_fifo_cleared", TW'(out_valid), TW'(0));
        chk("t6_busy", TW'(busy), TW'(1));
        out_ready = 1'b1;
        n_pop = 0;
        send_tile(16'h0400, 0, 1, 1'b1, 0);
        wait_done("t6_done", 10);
        chk("t6_pops", TW'(n_pop), TW'(1));

        // Asynchronous reset mid-tile
        out_ready = 1'b0;
        do_start(2);
        send_tile(16'h0500, 0, 2, 1'b0, 0);
        beat(16'h0600, 0);
        chk("t7_valid_pre_rst", TW'(out_valid), TW'(1));
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_data", out_data, '0);
        chk("t7_rst_valid", TW'(out_valid), TW'(0));
        chk("t7_rst_last", TW'(out_last), TW'(0));
        chk("t7_rst_busy", TW'(busy), TW'(0));
        chk("t7_rst_done", TW'(done), TW'(0));
        chk("t7_rst_ovf", TW'(overflow), TW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(2);
        chk("t7_post_rst_idle", TW'(busy), TW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
